regfile_write_arbiter: RTL and testbench

//  Shares the register file's single write port (wa3/wd3/we3) among NREQ writeback sources.

---
 rtl/regfile_write_arbiter.sv | 137 +++++++++++++
 tb/tb_regfile_write_arbiter.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register file write port among NREQ writeback
// sources, with one registered output stage and a scrub sequencer that zeroes x1..x31.
module regfile_write_arbiter #(
  parameter int NREQ = 3,
  parameter int AW   = 5,
  parameter int DW   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done,
  output logic [AW-1:0]     wa3,
  output logic [DW-1:0]     wd3,
  output logic              we3,
  output logic [1:0]        grant_id
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(31);

  typedef enum logic {IDLE, SCRUB} state_t;

  state_t          state_reg, state_next;
  logic [1:0]      ptr_reg;
  logic [AW-1:0]   cnt_reg;
  logic [AW-1:0]   wa3_reg;
  logic [DW-1:0]   wd3_reg;
  logic            we3_reg;
  logic [1:0]      grant_id_reg;
  logic            clr_done_reg;

  logic [AW-1:0]   addr_arr [NREQ];
  logic [DW-1:0]   data_arr [NREQ];

  logic            found;
  logic [1:0]      winner;
  logic [1:0]      ptr_adv;
  logic [AW-1:0]   win_addr;
  logic [DW-1:0]   win_data;
  logic            grant_ok;
  logic            accept;
  int              idx;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign addr_arr[gi] = req_addr[AW*gi +: AW];
    assign data_arr[gi] = req_data[DW*gi +: DW];
  end

  // Search starts at ptr and wraps; first valid requester wins.
  always_comb begin
    found    = 1'b0;
    winner   = '0;
    ptr_adv  = '0;
    win_addr = '0;
    win_data = '0;
    idx      = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr_reg) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req_valid[idx]) begin
        found    = 1'b1;
        winner   = 2'(idx);
        win_addr = addr_arr[idx];
        win_data = data_arr[idx];
        ptr_adv  = (idx + 1 >= NREQ) ? 2'd0 : 2'(idx + 1);
      end
    end
  end

  // A pending scrub request outranks every requester.
  assign grant_ok = rst && (state_reg == IDLE) && !clr_req;
  assign accept   = grant_ok && found;

  always_ff @(posedge clk) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (clr_req) state_next = SCRUB;
      SCRUB:   if (cnt_reg == LAST_ADDR) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    clr_busy  = (state_reg == SCRUB);
    req_ready = '0;
    for (int i = 0; i < NREQ; i++)
      req_ready[i] = accept && (int'(winner) == i);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_reg      <= '0;
      cnt_reg      <= '0;
      wa3_reg      <= '0;
      wd3_reg      <= '0;
      we3_reg      <= 1'b0;
      grant_id_reg <= '0;
      clr_done_reg <= 1'b0;
    end else begin
      we3_reg      <= 1'b0;
      clr_done_reg <= 1'b0;
      if (state_reg == SCRUB) begin
        wa3_reg      <= cnt_reg;
        wd3_reg      <= '0;
        we3_reg      <= 1'b1;
        grant_id_reg <= '0;
        cnt_reg      <= cnt_reg + AW'(1);
        if (cnt_reg == LAST_ADDR) clr_done_reg <= 1'b1;
      end else begin
        if (clr_req) cnt_reg <= AW'(1);
        if (accept) begin
          wa3_reg      <= win_addr;
          wd3_reg      <= win_data;
          we3_reg      <= (win_addr != '0);
          grant_id_reg <= winner;
          ptr_reg      <= ptr_adv;
        end
      end
    end
  end

  assign wa3      = wa3_reg;
  assign wd3      = wd3_reg;
  assign we3      = we3_reg;
  assign grant_id = grant_id_reg;
  assign clr_done = clr_done_reg;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: vector table for arbitration and
// output stage, plus hand sequences for scrub and reset-mid-scrub.
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req_valid;
  logic [2:0]  req_ready;
  logic [14:0] req_addr;
  logic [95:0] req_data;
  logic        clr_req;
  logic        clr_busy;
  logic        clr_done;
  logic [4:0]  wa3;
  logic [31:0] wd3;
  logic        we3;
  logic [1:0]  grant_id;

  int checks = 0;
  int errors = 0;

  regfile_write_arbiter #(.NREQ(3), .AW(5), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data),
    .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done),
    .wa3(wa3), .wd3(wd3), .we3(we3), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  valid;
    logic [14:0] addr;
    logic [95:0] data;
    logic [2:0]  ready;
    logic        we3;
    logic [4:0]  wa3;
    logic [31:0] wd3;
    logic [1:0]  gid;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  localparam logic [14:0] A321  = {5'd3, 5'd2, 5'd1};
  localparam logic [95:0] D_CBA = {32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001};

  initial begin
    // Per-row ptr progression from reset: 0 ->1 ->1 ->0 ->1 ->2 ->0 ->1 ->2 ->1 ->0 ->2
    vecs[0]  = '{3'b001, {10'd0, 5'd5}, {64'd0, 32'hDEADBEEF}, 3'b001, 1'b1, 5'd5, 32'hDEADBEEF, 2'd0};
    vecs[1]  = '{3'b000, {10'd0, 5'd5}, {64'd0, 32'hDEADBEEF}, 3'b000, 1'b0, 5'd5, 32'hDEADBEEF, 2'd0};
    vecs[2]  = '{3'b100, A321, D_CBA, 3'b100, 1'b1, 5'd3, 32'hCCCC_0003, 2'd2};
    vecs[3]  = '{3'b111, A321, D_CBA, 3'b001, 1'b1, 5'd1, 32'hAAAA_0001, 2'd0};
    vecs[4]  = '{3'b111, A321, D_CBA, 3'b010, 1'b1, 5'd2, 32'hBBBB_0002, 2'd1};
    vecs[5]  = '{3'b111, A321, D_CBA, 3'b100, 1'b1, 5'd3, 32'hCCCC_0003, 2'd2};
    vecs[6]  = '{3'b111, A321, D_CBA, 3'b001, 1'b1, 5'd1, 32'hAAAA_0001, 2'd0};
    vecs[7]  = '{3'b010, {5'd3, 5'd0, 5'd1}, {32'hCCCC_0003, 32'h55, 32'hAAAA_0001},
                 3'b010, 1'b0, 5'd0, 32'h55, 2'd1};
    vecs[8]  = '{3'b011, A321, D_CBA, 3'b001, 1'b1, 5'd1, 32'hAAAA_0001, 2'd0};
    vecs[9]  = '{3'b101, A321, D_CBA, 3'b100, 1'b1, 5'd3, 32'hCCCC_0003, 2'd2};
    vecs[10] = '{3'b110, A321, D_CBA, 3'b010, 1'b1, 5'd2, 32'hBBBB_0002, 2'd1};

    rst = 1'b0; req_valid = 3'b111; req_addr = '0; req_data = '0; clr_req = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_we3", 64'(we3), 64'd0);
    chk("rst_wa3", 64'(wa3), 64'd0);
    chk("rst_wd3", 64'(wd3), 64'd0);
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_busy", 64'(clr_busy), 64'd0);
    chk("rst_done", 64'(clr_done), 64'd0);
    chk("rst_gid", 64'(grant_id), 64'd0);
    rst = 1'b1; req_valid = '0;

    for (int v = 0; v < 11; v++) begin
      @(negedge clk);
      req_valid = vecs[v].valid; req_addr = vecs[v].addr; req_data = vecs[v].data;
      #1;
      chk($sformatf("v%0d_ready", v), 64'(req_ready), 64'(vecs[v].ready));
      @(posedge clk); #1;
      chk($sformatf("v%0d_we3", v), 64'(we3), 64'(vecs[v].we3));
      chk($sformatf("v%0d_wa3", v), 64'(wa3), 64'(vecs[v].wa3));
      chk($sformatf("v%0d_wd3", v), 64'(wd3), 64'(vecs[v].wd3));
      chk($sformatf("v%0d_gid", v), 64'(grant_id), 64'(vecs[v].gid));
      $display("vec %0d: valid=%b ready=%b wa3=%0d wd3=%h we3=%b gid=%0d",
               v, vecs[v].valid, req_ready, wa3, wd3, we3, grant_id);
    end

    // Scrub request collides with a valid requester: scrub wins.
    @(negedge clk);
    clr_req = 1'b1; req_valid = 3'b001;
    req_addr = {10'd0, 5'd7}; req_data = {64'd0, 32'h77};
    #1;
    chk("scr_start_ready", 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    chk("scr_start_we3", 64'(we3), 64'd0);
    @(negedge clk);
    clr_req = 1'b0;
    for (int k = 1; k <= 31; k++) begin
      chk($sformatf("scr%0d_busy", k), 64'(clr_busy), 64'd1);
      chk($sformatf("scr%0d_ready", k), 64'(req_ready), 64'd0);
      @(posedge clk); #1;
      chk($sformatf("scr%0d_wa3", k), 64'(wa3), 64'(k));
      chk($sformatf("scr%0d_wd3", k), 64'(wd3), 64'd0);
      chk($sformatf("scr%0d_we3", k), 64'(we3), 64'd1);
      chk($sformatf("scr%0d_done", k), 64'(clr_done), (k == 31) ? 64'd1 : 64'd0);
      $display("scrub %0d: wa3=%0d we3=%b done=%b", k, wa3, we3, clr_done);
      @(negedge clk);
    end
    chk("scr_end_busy", 64'(clr_busy), 64'd0);
    chk("scr_end_ready", 64'(req_ready), 64'b001);
    @(posedge clk); #1;
    chk("post_scr_wa3", 64'(wa3), 64'd7);
    chk("post_scr_wd3", 64'(wd3), 64'h77);
    chk("post_scr_we3", 64'(we3), 64'd1);
    chk("post_scr_done", 64'(clr_done), 64'd0);
    $display("post-scrub grant: wa3=%0d wd3=%h we3=%b", wa3, wd3, we3);

    // Reset in the middle of a scrub aborts it without clr_done.
    begin
      logic seen10;
      logic done_seen;
      logic busy_seen;
      seen10 = 1'b0; done_seen = 1'b0; busy_seen = 1'b0;
      @(negedge clk);
      req_valid = '0; clr_req = 1'b1;
      @(posedge clk);
      @(negedge clk);
      clr_req = 1'b0;
      for (int c = 0; c < 40 && !seen10; c++) begin
        @(posedge clk); #1;
        if (wa3 == 5'd10) seen10 = 1'b1;
      end
      chk("wait_wa3_10", 64'(seen10), 64'd1);
      @(negedge clk);
      rst = 1'b0; req_valid = 3'b111;
      #1;
      chk("mid_rst_ready", 64'(req_ready), 64'd0);
      @(posedge clk); #1;
      chk("mid_rst_we3", 64'(we3), 64'd0);
      chk("mid_rst_wa3", 64'(wa3), 64'd0);
      chk("mid_rst_busy", 64'(clr_busy), 64'd0);
      chk("mid_rst_done", 64'(clr_done), 64'd0);
      @(negedge clk);
      rst = 1'b1; req_valid = '0;
      repeat (35) begin
        @(posedge clk); #1;
        if (clr_done) done_seen = 1'b1;
        if (clr_busy) busy_seen = 1'b1;
      end
      chk("abort_no_done", 64'(done_seen), 64'd0);
      chk("abort_no_busy", 64'(busy_seen), 64'd0);
      $display("reset mid-scrub: done_seen=%b busy_seen=%b", done_seen, busy_seen);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
